// File: rtl/rnd_word_gen.sv
// rnd_word_gen
//   XNOR-feedback Fibonacci LFSR that emits OUT_W pseudo-random bits per word
//   on a valid/ready stream. It uses the same tap/shift convention as the
//   single-bit rnd_m generator (xapp052/xapp211 tap tables). It also provides
//   a runtime seed load that rejects the all-ones lockup seed, and a
//   saturating count of accepted words.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   en         generation enable
//   seed_load  one-cycle strobe; load seed into the LFSR
//   seed       N-bit seed value
//   seed_err   one-cycle pulse after an all-ones seed was rejected
//   out_data   random word; bit 0 is the first bit shifted out
//   out_valid  out_data holds a word
//   out_ready  consumer accepts the word
//   word_cnt   saturating count of accepted words
//
// State mapping: stage S[k] lives in lfsr[k-1]. A step shifts toward the
// MSB, so S[N] (lfsr[N-1]) is the bit that falls out and the feedback enters
// at lfsr[0].

module rnd_word_gen #(
  parameter int             N            = 31,
  parameter logic [N-1:0]   TAPS         = 31'h4800_0000,
  parameter int             OUT_W        = 8,
  parameter logic [N-1:0]   SEED_DEFAULT = '0,
  parameter int             CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [N-1:0]     seed,
  output logic             seed_err,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt
);

  if (N < 3 || N > 64) begin : g_bad_n
    $error("rnd_word_gen: N must be in 3..64");
  end
  if (OUT_W < 1 || OUT_W > N) begin : g_bad_out_w
    $error("rnd_word_gen: OUT_W must be in 1..N");
  end
  if (TAPS == '0) begin : g_bad_taps
    $error("rnd_word_gen: TAPS must not be zero");
  end
  if (&SEED_DEFAULT) begin : g_bad_seed
    $error("rnd_word_gen: SEED_DEFAULT must not be the all-ones lockup state");
  end

  logic [N-1:0]     lfsr;
  logic [N-1:0]     step_st;
  logic [OUT_W-1:0] word_nxt;

  // OUT_W single steps unrolled; XNOR feedback keeps all-ones unreachable.
  always_comb begin
    step_st  = lfsr;
    word_nxt = '0;
    for (int j = 0; j < OUT_W; j++) begin
      word_nxt[j] = step_st[N-1];
      step_st     = {step_st[N-2:0], ~(^(step_st & TAPS))};
    end
  end

  logic accept;
  logic gen;

  assign accept = out_valid & out_ready;
  assign gen    = en & (~out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED_DEFAULT;
      out_valid <= 1'b0;
      out_data  <= '0;
      seed_err  <= 1'b0;
      word_cnt  <= '0;
    end else begin
      seed_err <= 1'b0;
      if (seed_load) begin
        // Any word in the output register is dropped uncounted.
        if (&seed) begin
          lfsr     <= '0;
          seed_err <= 1'b1;
        end else begin
          lfsr <= seed;
        end
        out_valid <= 1'b0;
        word_cnt  <= '0;
      end else begin
        if (accept && (word_cnt != '1)) begin
          word_cnt <= word_cnt + CNT_W'(1);
        end
        if (gen) begin
          out_data  <= word_nxt;
          lfsr      <= step_st;
          out_valid <= 1'b1;
        end else if (accept) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rnd_word_gen.sv
// Scoreboard bench for rnd_word_gen: three instances cover the 3-stage
// single-bit stream (with a 4-bit counter for saturation), the 3-stage
// full-period word, and the default 31-stage configuration.

module tb_rnd_word_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // instance a: N=3, TAPS=110, OUT_W=1, CNT_W=4
  logic       en_a, sl_a, rdy_a, serr_a, val_a;
  logic [2:0] seed_a;
  logic [0:0] data_a;
  logic [3:0] cnt_a;

  // instance b: N=3, TAPS=110, OUT_W=7
  logic        en_b, sl_b, rdy_b, serr_b, val_b;
  logic [2:0]  seed_b;
  logic [6:0]  data_b;
  logic [31:0] cnt_b;

  // instance c: defaults
  logic        en_c, sl_c, rdy_c, serr_c, val_c;
  logic [30:0] seed_c;
  logic [7:0]  data_c;
  logic [31:0] cnt_c;

  rnd_word_gen #(.N(3), .TAPS(3'b110), .OUT_W(1), .SEED_DEFAULT(3'b000), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .seed_load(sl_a), .seed(seed_a),
    .seed_err(serr_a), .out_data(data_a), .out_valid(val_a),
    .out_ready(rdy_a), .word_cnt(cnt_a));

  rnd_word_gen #(.N(3), .TAPS(3'b110), .OUT_W(7), .SEED_DEFAULT(3'b000), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .seed_load(sl_b), .seed(seed_b),
    .seed_err(serr_b), .out_data(data_b), .out_valid(val_b),
    .out_ready(rdy_b), .word_cnt(cnt_b));

  rnd_word_gen u_c (
    .clk(clk), .rst(rst), .en(en_c), .seed_load(sl_c), .seed(seed_c),
    .seed_err(serr_c), .out_data(data_c), .out_valid(val_c),
    .out_ready(rdy_c), .word_cnt(cnt_c));

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: a word counts as accepted when valid & ready reach an edge
  // without seed_load or rst.
  always @(negedge clk) begin
    if (!rst && !sl_a && val_a && rdy_a) begin
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_word: got %0h expected none", data_a);
      end else check("a_word", 64'(data_a), 64'(q_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && !sl_b && val_b && rdy_b) begin
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_word: got %0h expected none", data_b);
      end else check("b_word", 64'(data_b), 64'(q_b.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && !sl_c && val_c && rdy_c) begin
      if (q_c.size() == 0) begin
        tests++; fails++;
        $display("FAIL c_word: got %0h expected none", data_c);
      end else check("c_word", 64'(data_c), 64'(q_c.pop_front()));
    end
  end

  logic [7:0] pat_a [7];

  initial begin
    pat_a = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1};

    rst = 1'b1;
    en_a = 0; sl_a = 0; rdy_a = 0; seed_a = '0;
    en_b = 0; sl_b = 0; rdy_b = 0; seed_b = '0;
    en_c = 0; rdy_c = 0;
    // seed_load together with rst: rst must win
    sl_c = 1; seed_c = '1;
    tick(1);
    check("rst_seed_err_c", 64'(serr_c), 64'd0);
    seed_c = 31'h5A00_0000;
    tick(1);
    check("rst_lfsr_c", 64'(u_c.lfsr), 64'd0);
    check("rst_seed_err_c2", 64'(serr_c), 64'd0);
    check("rst_valid_a", 64'(val_a), 64'd0);
    check("rst_valid_b", 64'(val_b), 64'd0);
    check("rst_valid_c", 64'(val_c), 64'd0);
    check("rst_data_c", 64'(data_c), 64'd0);
    check("rst_cnt_a", 64'(cnt_a), 64'd0);
    check("rst_cnt_b", 64'(cnt_b), 64'd0);
    check("rst_cnt_c", 64'(cnt_c), 64'd0);
    check("rst_serr_a", 64'(serr_a), 64'd0);
    check("rst_serr_b", 64'(serr_b), 64'd0);

    // ---- a: single-bit stream 0,0,0,1,1,0,1 and counter saturation ----
    rst = 1'b0; sl_c = 0;
    en_a = 1; rdy_a = 1;
    for (int i = 0; i < 21; i++) q_a.push_back(pat_a[i % 7]);
    tick(1);
    check("a_latency", 64'(val_a), 64'd1);
    tick(14);
    check("a_cnt14", 64'(cnt_a), 64'd14);
    tick(6);
    check("a_cnt_sat", 64'(cnt_a), 64'd15);
    en_a = 0;
    tick(1);
    check("a_drain_valid", 64'(val_a), 64'd0);
    check("a_drain_lfsr", 64'(u_a.lfsr), 64'd0);
    check("a_drain_cnt", 64'(cnt_a), 64'd15);
    tick(1);
    check("a_idle_lfsr", 64'(u_a.lfsr), 64'd0);
    check("a_idle_valid", 64'(val_a), 64'd0);
    rdy_a = 0;

    // ---- b: 7-bit words cover the full period -> always 7'h58 ----
    en_b = 1; rdy_b = 1;
    repeat (5) q_b.push_back(8'h58);
    tick(1);
    check("b_lfsr_wrap", 64'(u_b.lfsr), 64'd0);
    tick(4);
    en_b = 0;
    tick(1);
    check("b_cnt", 64'(cnt_b), 64'd5);
    check("b_valid", 64'(val_b), 64'd0);
    check("b_lfsr_end", 64'(u_b.lfsr), 64'd0);
    rdy_b = 0;

    // ---- c: defaults, backpressure, seed loads ----
    en_c = 1; rdy_c = 1;
    q_c.push_back(8'h00); q_c.push_back(8'h00);
    q_c.push_back(8'h00); q_c.push_back(8'h80);
    tick(2);
    rdy_c = 0;
    tick(1);
    check("c_hold_lfsr1", 64'(u_c.lfsr), 64'h0000_FFFF);
    check("c_hold_valid1", 64'(val_c), 64'd1);
    tick(1);
    check("c_hold_lfsr2", 64'(u_c.lfsr), 64'h0000_FFFF);
    check("c_hold_valid2", 64'(val_c), 64'd1);
    check("c_hold_cnt", 64'(cnt_c), 64'd1);
    rdy_c = 1;
    tick(2);
    check("c_cnt3", 64'(cnt_c), 64'd3);
    tick(1);
    check("c_w4", 64'(data_c), 64'hFF);
    check("c_cnt4", 64'(cnt_c), 64'd4);
    // all-ones seed while a word is being accepted
    sl_c = 1; seed_c = '1;
    tick(1);
    check("c_seed_err", 64'(serr_c), 64'd1);
    check("c_seed_lfsr", 64'(u_c.lfsr), 64'd0);
    check("c_seed_valid", 64'(val_c), 64'd0);
    check("c_seed_cnt", 64'(cnt_c), 64'd0);
    sl_c = 0;
    tick(1);
    check("c_seed_err_clr", 64'(serr_c), 64'd0);
    check("c_gen_after_seed", 64'(val_c), 64'd1);
    check("c_data_zero_seed", 64'(data_c), 64'd0);
    // normal seed flushes the pending word
    sl_c = 1; seed_c = 31'h5A00_0000;
    tick(1);
    check("c_seed2_lfsr", 64'(u_c.lfsr), 64'h5A00_0000);
    check("c_seed2_err", 64'(serr_c), 64'd0);
    check("c_seed2_cnt", 64'(cnt_c), 64'd0);
    check("c_seed2_valid", 64'(val_c), 64'd0);
    sl_c = 0;
    q_c.push_back(8'h2D);
    tick(1);
    check("c_seed2_word", 64'(data_c), 64'h2D);
    en_c = 0;
    tick(1);
    check("c_drain_valid", 64'(val_c), 64'd0);
    check("c_drain_cnt", 64'(cnt_c), 64'd1);
    rdy_c = 0;

    tick(2);
    check("a_queue_empty", 64'(q_a.size()), 64'd0);
    check("b_queue_empty", 64'(q_b.size()), 64'd0);
    check("c_queue_empty", 64'(q_c.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
